// File: rtl/rast_pkg.sv
// Shared rasterizer definitions: traversal FSM states, fixed-point defaults
// and the subsample step decode.
package rast_pkg;

  localparam int unsigned SIGFIG_DEF = 24;
  localparam int unsigned RADIX_DEF  = 10;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } state_t;

  // One-hot subsample select to a step in fixed-point units. Illegal codes
  // fall back to a full pixel so traversal always makes forward progress.
  function automatic logic [31:0] step_decode(input logic [3:0]  sub,
                                              input int unsigned radix);
    logic [31:0] one;
    one = 32'd1;
    case (sub)
      4'b1000: step_decode = one << radix;
      4'b0100: step_decode = one << (radix - 1);
      4'b0010: step_decode = one << (radix - 2);
      4'b0001: step_decode = one << (radix - 3);
      default: step_decode = one << radix;
    endcase
  endfunction

endpackage

// File: rtl/sample_lane_gen.sv
// One sample lane: position base.x + LANE*step on the current row, valid
// while that position lies at or left of the box's right edge.
module sample_lane_gen #(
  parameter int SIGFIG = 24,
  parameter int LANE   = 0
) (
  input  logic signed [SIGFIG+1:0] base_x,
  input  logic        [SIGFIG-1:0] base_y,
  input  logic signed [SIGFIG+1:0] step,
  input  logic signed [SIGFIG+1:0] ur_x,
  output logic        [SIGFIG-1:0] samp_x,
  output logic        [SIGFIG-1:0] samp_y,
  output logic                     valid
);

  localparam int W = SIGFIG + 2;
  localparam logic signed [W-1:0] IDX = W'(LANE);

  logic signed [W-1:0] lane_x;

  always_comb begin
    lane_x = base_x + IDX * step;
    samp_x = lane_x[SIGFIG-1:0];
    samp_y = base_y;
    valid  = (lane_x <= ur_x);
  end

endmodule

// File: rtl/sample_iter_ctrl.sv
// Walks a triangle's snapped bounding box row by row, emitting MULTI_TEST
// sample positions per cycle with per-lane valids and a last-row pulse.
module sample_iter_ctrl
  import rast_pkg::*;
#(
  parameter int SIGFIG     = SIGFIG_DEF,
  parameter int RADIX      = RADIX_DEF,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int MULTI_TEST = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                         validTri_R13H,
  input  logic        [3:0]                            subSample_RnnnnU,
  input  logic                                         halt_in,
  output logic                                         halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic signed [MULTI_TEST-1:0][1:0][SIGFIG-1:0] sample_R14S,
  output logic        [MULTI_TEST-1:0]                 validSamp_R14H,
  output logic                                         tri_done_R14H
);

  localparam int W = SIGFIG + 2;
  localparam logic signed [W-1:0] M_W = W'(MULTI_TEST);

  function automatic logic signed [W-1:0] sx(input logic [SIGFIG-1:0] v);
    sx = W'($signed(v));
  endfunction

  state_t state;

  logic [SIGFIG-1:0] ll_x_r, ur_x_r, ur_y_r;
  logic [SIGFIG-1:0] step_r, step_dec;
  logic [SIGFIG-1:0] base_x, base_y;

  logic                box_ok, accept, nxt_last;
  logic signed [W-1:0] cur_step, adv_x_sum, adv_y_sum;
  logic signed [W-1:0] sel_step, sel_ur_x, sel_ur_y;
  logic signed [W-1:0] nxt_x, nxt_y;

  logic [MULTI_TEST-1:0][SIGFIG-1:0] lane_x, lane_y;
  logic [MULTI_TEST-1:0]             lane_v;

  // The lanes always see the row about to be registered: the box's LL corner
  // on accept, otherwise the advanced position. nxt_last looks one row ahead
  // so tri_done coincides with the final row rather than trailing it.
  always_comb begin
    step_dec  = SIGFIG'(step_decode(subSample_RnnnnU, RADIX));
    box_ok    = (sx(box_R13S[0][0]) <= sx(box_R13S[1][0])) &&
                (sx(box_R13S[0][1]) <= sx(box_R13S[1][1]));
    accept    = (state == WAIT) && validTri_R13H && !halt_in && box_ok;
    cur_step  = $signed(W'(step_r));
    adv_x_sum = sx(base_x) + M_W * cur_step;
    adv_y_sum = sx(base_y) + cur_step;
    if (state == WAIT) begin
      sel_step = $signed(W'(step_dec));
      sel_ur_x = sx(box_R13S[1][0]);
      sel_ur_y = sx(box_R13S[1][1]);
      nxt_x    = sx(box_R13S[0][0]);
      nxt_y    = sx(box_R13S[0][1]);
    end else begin
      sel_step = cur_step;
      sel_ur_x = sx(ur_x_r);
      sel_ur_y = sx(ur_y_r);
      if (adv_x_sum <= sx(ur_x_r)) begin
        nxt_x = adv_x_sum;
        nxt_y = sx(base_y);
      end else begin
        nxt_x = sx(ll_x_r);
        nxt_y = adv_y_sum;
      end
    end
    nxt_last = (nxt_x + M_W * sel_step > sel_ur_x) &&
               (nxt_y + sel_step > sel_ur_y);
  end

  for (genvar i = 0; i < MULTI_TEST; i++) begin : g_lane
    sample_lane_gen #(
      .SIGFIG (SIGFIG),
      .LANE   (i)
    ) u_lane (
      .base_x (nxt_x),
      .base_y (nxt_y[SIGFIG-1:0]),
      .step   (sel_step),
      .ur_x   (sel_ur_x),
      .samp_x (lane_x[i]),
      .samp_y (lane_y[i]),
      .valid  (lane_v[i])
    );
  end

  always_comb begin
    halt_RnnnnL = (state == TEST) | halt_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= WAIT;
      ll_x_r         <= '0;
      ur_x_r         <= '0;
      ur_y_r         <= '0;
      step_r         <= '0;
      base_x         <= '0;
      base_y         <= '0;
      tri_R14S       <= '0;
      color_R14U     <= '0;
      sample_R14S    <= '0;
      validSamp_R14H <= '0;
      tri_done_R14H  <= 1'b0;
    end else if (!halt_in) begin
      case (state)
        WAIT: begin
          validSamp_R14H <= '0;
          tri_done_R14H  <= 1'b0;
          if (accept) begin
            state      <= TEST;
            tri_R14S   <= tri_R13S;
            color_R14U <= color_R13U;
            ll_x_r     <= box_R13S[0][0];
            ur_x_r     <= box_R13S[1][0];
            ur_y_r     <= box_R13S[1][1];
            step_r     <= step_dec;
            base_x     <= nxt_x[SIGFIG-1:0];
            base_y     <= nxt_y[SIGFIG-1:0];
            for (int unsigned i = 0; i < MULTI_TEST; i++) begin
              sample_R14S[i][0] <= lane_x[i];
              sample_R14S[i][1] <= lane_y[i];
            end
            validSamp_R14H <= lane_v;
            tri_done_R14H  <= nxt_last;
          end
        end
        TEST: begin
          if (tri_done_R14H) begin
            state          <= WAIT;
            validSamp_R14H <= '0;
            tri_done_R14H  <= 1'b0;
          end else begin
            base_x <= nxt_x[SIGFIG-1:0];
            base_y <= nxt_y[SIGFIG-1:0];
            for (int unsigned i = 0; i < MULTI_TEST; i++) begin
              sample_R14S[i][0] <= lane_x[i];
              sample_R14S[i][1] <= lane_y[i];
            end
            validSamp_R14H <= lane_v;
            tri_done_R14H  <= nxt_last;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: doc/sample_iter_ctrl.md
SAMPLE_ITER_CTRL -- requirements
Module: sample_iter_ctrl

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, meaning bits per fixed-point coordinate/color.
REQ-002 SHALL have parameter RADIX, default 10, meaning fraction bits.
REQ-003 SHALL have parameter VERTS, default 3, meaning vertices per triangle.
REQ-004 SHALL have parameter AXIS, default 3, meaning axes per vertex.
REQ-005 SHALL have parameter COLORS, default 3, meaning color channels.
REQ-006 SHALL have parameter MULTI_TEST, default 4, meaning sample lanes emitted per cycle.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port tri_R13S, input, signed [VERTS][AXIS]xSIGFIG, triangle vertices.
REQ-010 SHALL have port color_R13U, input, [COLORS]xSIGFIG, triangle color.
REQ-011 SHALL have port box_R13S, input, signed [2][2]xSIGFIG, snapped bounding box: [0]=LL(x,y), [1]=UR(x,y).
REQ-012 SHALL have port validTri_R13H, input, 1, triangle/box valid.
REQ-013 SHALL have port subSample_RnnnnU, input, 4, one-hot sample-step select.
REQ-014 SHALL have port halt_in, input, 1, downstream stall.
REQ-015 SHALL have port halt_RnnnnL, output, 1, upstream stall.
REQ-016 SHALL have ports tri_R14S and color_R14U, outputs, the captured triangle and color, same widths as inputs.
REQ-017 SHALL have port sample_R14S, output, signed [MULTI_TEST][2]xSIGFIG, lane sample (x,y).
REQ-018 SHALL have port validSamp_R14H, output, [MULTI_TEST]x1, per-lane valid.
REQ-019 SHALL have port tri_done_R14H, output, 1, single-cycle pulse when a triangle's last samples are emitted.

Function
REQ-020 SHALL implement FSM WAIT/TEST; halt_RnnnnL = (state==TEST) | halt_in.
REQ-021 Step SHALL be 1<<RADIX for 4'b1000, 1<<(RADIX-1) for 4'b0100, 1<<(RADIX-2) for 4'b0010, 1<<(RADIX-3) for 4'b0001; step is latched at triangle accept.
REQ-022 In WAIT, with validTri_R13H=1, halt_in=0 and LL<=UR on both axes, SHALL capture tri, color, box and step, set base=LL, and enter TEST.
REQ-023 A triangle with LL.x>UR.x or LL.y>UR.y SHALL be dropped: the FSM stays in WAIT, emits no valid samples and no tri_done pulse.
REQ-024 Latency: the first sample row SHALL appear on the outputs the cycle after accept.
REQ-025 In TEST, lane i SHALL carry (base.x+i*step, base.y); its valid bit SHALL be 1 iff lane x<=UR.x.
REQ-026 Each non-halted TEST cycle SHALL advance: if base.x+MULTI_TEST*step<=UR.x, base.x advances by MULTI_TEST*step; else if base.y+step<=UR.y, base.x=LL.x and base.y advances by step; else the block asserts tri_done and returns to WAIT.
REQ-027 Position sums and comparisons SHALL be signed, computed in SIGFIG+2 bits, and compared before truncation, so they never wrap.
REQ-028 While halt_in=1, state, base and all outputs SHALL hold, and no triangle is accepted.
REQ-029 In WAIT, validSamp_R14H SHALL be all 0.
REQ-030 A new triangle SHALL NOT be accepted in the same cycle as tri_done; the earliest accept is the next cycle.

Reset
REQ-031 On rst=0, asynchronously: state=WAIT; all outputs, base, box and step registers=0; halt_RnnnnL=0.
REQ-032 A reset asserted mid-TEST SHALL abandon the triangle, with no tri_done pulse.

Structure
REQ-033 Shared package rast_pkg SHALL hold the FSM state enum, the subsample step-decode function and the SIGFIG/RADIX defaults.
REQ-034 Lane position/valid generation SHALL be one combinational sub-module, sample_lane_gen, instantiated once per lane.

Verification
REQ-035 LL=(0,0), UR=(3,1) px, step 1 px, MULTI_TEST=4 -> row y=0 with x=0..3 all valid, then row y=1, tri_done, halt_RnnnnL high exactly 2 cycles.
REQ-036 UR.x=5 px, one row -> cycle1 lanes x=0..3 valid; cycle2 x=4,5 valid, lanes 2-3 invalid, tri_done.
REQ-037 halt_in high for 3 cycles mid-traversal -> outputs frozen, total valid-sample count unchanged versus the unhalted run (8 for REQ-035 box).
REQ-038 LL.x>UR.x -> zero valid samples, halt_RnnnnL stays low, no tri_done.
REQ-039 subSample 4'b0010, LL=(0,0), UR=(1,0) px -> x=0,256,512,768 valid, then x=1024 valid in lane 0, tri_done.
REQ-040 rst low mid-TEST -> all outputs 0 immediately; a following triangle processes correctly.
